// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared types and constants for the ALU mutation fuzz engine
package fuzz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ISOLATE,
        MUTATE,
        APPLY,
        REPORT,
        RECONNECT
    } fuzz_state_e;

    typedef enum logic [1:0] {
        MODE_XOR,
        MODE_ROT,
        MODE_BITFLIP,
        MODE_OPINV
    } mut_mode_e;

    localparam logic [7:0] MUT_XOR_CONST = 8'hA5;

    localparam int MUT_DATA_W = 32;
    localparam int MUT_OP_W   = 4;

    // Field order matches the {a, b, op} packing held in the mutant FIFO.
    typedef struct packed {
        logic [MUT_DATA_W-1:0] a;
        logic [MUT_DATA_W-1:0] b;
        logic [MUT_OP_W-1:0]   op;
    } mutant_t;

endpackage

// File: rtl/fuzz_mutant_fifo.sv
// rtl/fuzz_mutant_fifo.sv - synchronous mutant FIFO with flush, full/empty from a wrap bit
module fuzz_mutant_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/alu_fuzz_engine.sv
// rtl/alu_fuzz_engine.sv - seed capture, mutant generation and replay against an isolated ALU
// Optional LFSR-driven mode-3 mutation is enabled by defining FUZZ_LFSR_MUTATION_EN.
module alu_fuzz_engine
    import fuzz_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int DEPTH   = 16,
    parameter int NUM_MUT = 8,
    parameter int TIMEOUT = 100
`ifdef FUZZ_LFSR_MUTATION_EN
    ,
    parameter logic [31:0] LFSR_SEED = 32'h1D872B41
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mon_valid,
    input  logic [DATA_W-1:0] mon_a,
    input  logic [DATA_W-1:0] mon_b,
    input  logic [OP_W-1:0]   mon_op,
    output logic              isolate,
    output logic              dut_req_valid,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    output logic [OP_W-1:0]   dut_op,
    input  logic              dut_rsp_valid,
    input  logic              dut_rsp_err,
    input  logic [DATA_W-1:0] dut_result,
    input  logic              dut_carry,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [DATA_W:0]   rpt_data,
    output logic              crash_detected,
    output logic              hang_detected,
    output logic              ack
);

    localparam int FW = 2*DATA_W + OP_W;
    localparam int KW = $clog2(NUM_MUT + 1) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic logic [DATA_W-1:0] xor_pattern();
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) begin
            p[i] = MUT_XOR_CONST[i % 8];
        end
        return p;
    endfunction

    localparam logic [DATA_W-1:0] XOR_PAT = xor_pattern();

    fuzz_state_e       state;
    logic [DATA_W-1:0] seed_a;
    logic [DATA_W-1:0] seed_b;
    logic [OP_W-1:0]   seed_op;
    logic [KW-1:0]     mut_k;
    logic [TW-1:0]     timer;

    logic [DATA_W-1:0] mut_a;
    logic [DATA_W-1:0] mut_b;
    logic [OP_W-1:0]   mut_op;
    logic [DATA_W-1:0] flip_mask;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_rdata;

`ifdef FUZZ_LFSR_MUTATION_EN
    function automatic logic [DATA_W-1:0] fit32(input logic [31:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[i % 32];
        end
        return r;
    endfunction

    logic [31:0]       lfsr;
    logic [DATA_W-1:0] lfsr_a;
    logic [DATA_W-1:0] lfsr_b;

    // Galois form of x^32 + x^22 + x^2 + x + 1, advanced once per pushed mutant.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (fifo_push) begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
    end

    assign lfsr_a = fit32(lfsr);
    assign lfsr_b = fit32({lfsr[15:0], lfsr[31:16]});
`endif

    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            flip_mask[i] = (i == (int'(mut_k) % DATA_W));
        end
    end

    always_comb begin
        mut_a  = seed_a;
        mut_b  = seed_b;
        mut_op = seed_op;
        case (mut_mode_e'(mut_k[1:0]))
            MODE_XOR: begin
                mut_a = seed_a ^ XOR_PAT;
                mut_b = ~seed_b;
            end
            MODE_ROT: begin
                mut_a = {seed_a[DATA_W-2:0], seed_a[DATA_W-1]};
                mut_b = {seed_b[0], seed_b[DATA_W-1:1]};
            end
            MODE_BITFLIP: begin
                mut_a = seed_a ^ flip_mask;
            end
            MODE_OPINV: begin
`ifdef FUZZ_LFSR_MUTATION_EN
                mut_a = seed_a ^ lfsr_a;
                mut_b = seed_b ^ lfsr_b;
`else
                mut_op = ~seed_op;
`endif
            end
            default: begin
            end
        endcase
    end

    // A full FIFO ends MUTATE instead of stalling; remaining mutants are dropped.
    assign fifo_push  = (state == MUTATE) && (mut_k < KW'(NUM_MUT)) && !fifo_full;
    assign fifo_pop   = (state == APPLY) && !dut_req_valid && !fifo_empty;
    assign fifo_flush = (state == APPLY) && dut_req_valid && !dut_rsp_valid
                        && (timer == TW'(TIMEOUT - 1));

    fuzz_mutant_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({mut_a, mut_b, mut_op}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .flush (fifo_flush),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            seed_a         <= '0;
            seed_b         <= '0;
            seed_op        <= '0;
            mut_k          <= '0;
            timer          <= '0;
            isolate        <= 1'b0;
            dut_req_valid  <= 1'b0;
            dut_a          <= '0;
            dut_b          <= '0;
            dut_op         <= '0;
            rpt_valid      <= 1'b0;
            rpt_data       <= '0;
            crash_detected <= 1'b0;
            hang_detected  <= 1'b0;
            ack            <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        crash_detected <= 1'b0;
                        hang_detected  <= 1'b0;
                        state          <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (mon_valid) begin
                        seed_a  <= mon_a;
                        seed_b  <= mon_b;
                        seed_op <= mon_op;
                        mut_k   <= '0;
                        isolate <= 1'b1;
                        state   <= ISOLATE;
                    end
                end
                ISOLATE: begin
                    state <= MUTATE;
                end
                MUTATE: begin
                    if (fifo_push) begin
                        mut_k <= mut_k + KW'(1);
                    end else begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (!dut_req_valid) begin
                        if (!fifo_empty) begin
                            {dut_a, dut_b, dut_op} <= fifo_rdata;
                            dut_req_valid          <= 1'b1;
                            timer                  <= '0;
                        end else begin
                            state <= RECONNECT;
                        end
                    end else if (dut_rsp_valid) begin
                        // Checked before the timeout so a last-cycle response is not a hang.
                        dut_req_valid <= 1'b0;
                        rpt_valid     <= 1'b1;
                        rpt_data      <= {dut_carry, dut_result};
                        if (dut_rsp_err) begin
                            crash_detected <= 1'b1;
                        end
                        state <= REPORT;
                    end else if (fifo_flush) begin
                        hang_detected <= 1'b1;
                        dut_req_valid <= 1'b0;
                        state         <= RECONNECT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= fifo_empty ? RECONNECT : APPLY;
                    end
                end
                RECONNECT: begin
                    isolate <= 1'b0;
                    ack     <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_fuzz_engine.sv
// tb/tb_alu_fuzz_engine.sv - directed self-checking bench for alu_fuzz_engine
module tb_alu_fuzz_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mon_valid = 1'b0;
    logic [31:0] mon_a = '0;
    logic [31:0] mon_b = '0;
    logic [3:0]  mon_op = '0;
    logic        dut_rsp_valid = 1'b0;
    logic        dut_rsp_err = 1'b0;
    logic [31:0] dut_result = '0;
    logic        dut_carry = 1'b0;
    logic        rpt_ready = 1'b0;

    logic        isolate, dut_req_valid, rpt_valid, crash_detected, hang_detected, ack;
    logic [31:0] dut_a, dut_b;
    logic [3:0]  dut_op;
    logic [32:0] rpt_data;

    logic        enable_s = 1'b0;
    logic        rpt_ready_s = 1'b1;
    logic        rsp_valid_s;
    logic        isolate_s, req_valid_s, rpt_valid_s, crash_s, hang_s, ack_s;
    logic [31:0] dut_a_s, dut_b_s;
    logic [3:0]  dut_op_s;
    logic [32:0] rpt_data_s;

    assign rsp_valid_s = req_valid_s;

    alu_fuzz_engine #(.NUM_MUT(4)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mon_valid(mon_valid),
        .mon_a(mon_a), .mon_b(mon_b), .mon_op(mon_op),
        .isolate(isolate), .dut_req_valid(dut_req_valid),
        .dut_a(dut_a), .dut_b(dut_b), .dut_op(dut_op),
        .dut_rsp_valid(dut_rsp_valid), .dut_rsp_err(dut_rsp_err),
        .dut_result(dut_result), .dut_carry(dut_carry),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data),
        .crash_detected(crash_detected), .hang_detected(hang_detected), .ack(ack)
    );

    alu_fuzz_engine #(.DEPTH(4), .NUM_MUT(6)) u_small (
        .clk(clk), .rst(rst), .enable(enable_s), .mon_valid(mon_valid),
        .mon_a(mon_a), .mon_b(mon_b), .mon_op(mon_op),
        .isolate(isolate_s), .dut_req_valid(req_valid_s),
        .dut_a(dut_a_s), .dut_b(dut_b_s), .dut_op(dut_op_s),
        .dut_rsp_valid(rsp_valid_s), .dut_rsp_err(dut_rsp_err),
        .dut_result(dut_result), .dut_carry(dut_carry),
        .rpt_valid(rpt_valid_s), .rpt_ready(rpt_ready_s), .rpt_data(rpt_data_s),
        .crash_detected(crash_s), .hang_detected(hang_s), .ack(ack_s)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("flags_cleared", {crash_detected, hang_detected}, 2'b00);
        mon_valid = 1'b1;
        mon_a = a;
        mon_b = b;
        mon_op = op;
        tick();
        mon_valid = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!dut_req_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic serve(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [3:0] eop, input logic err, input logic [31:0] res,
                         input logic cy, input int hold);
        int  n;
        bit  ok;
        wait_req(n);
        chk({tag, "_req"}, {dut_req_valid, dut_a, dut_b, dut_op}, {1'b1, ea, eb, eop});
        tick();
        chk({tag, "_held"}, {dut_req_valid, dut_a, dut_b, dut_op}, {1'b1, ea, eb, eop});
        dut_rsp_valid = 1'b1;
        dut_rsp_err   = err;
        dut_result    = res;
        dut_carry     = cy;
        tick();
        dut_rsp_valid = 1'b0;
        dut_rsp_err   = 1'b0;
        dut_result    = ~res;
        dut_carry     = ~cy;
        chk({tag, "_rpt"}, {rpt_valid, dut_req_valid, rpt_data}, {1'b1, 1'b0, cy, res});
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!(rpt_valid && rpt_data == {cy, res} && !dut_req_valid)) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_stall"}, ok, 1'b1);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk({tag, "_accepted"}, rpt_valid, 1'b0);
    endtask

    task automatic finish_campaign(input string tag);
        tick();
        chk({tag, "_ack"}, {ack, isolate}, 2'b10);
        tick();
        chk({tag, "_ack_pulse"}, ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int applied;
        int first_lat;
        logic [3:0] last_op;

        tick();
        tick();
        chk("reset_ctrl", {isolate, dut_req_valid, rpt_valid, crash_detected, hang_detected, ack}, 6'b0);
        chk("reset_data", {dut_a, dut_b, dut_op, rpt_data}, 101'b0);
        rst = 1'b0;
        tick();

        // Basic campaign: four mutants of seed (1, 2, 3)
        start(32'h1, 32'h2, 4'h3);
        wait_req(n);
        chk("first_req_latency", n, 7);
        chk("isolated", isolate, 1'b1);
        serve("t1_m0", 32'hA5A5_A5A4, 32'hFFFF_FFFD, 4'h3, 1'b0, 32'h1111_0000, 1'b1, 0);
        serve("t1_m1", 32'h2, 32'h1, 4'h3, 1'b0, 32'h2222_0000, 1'b0, 0);
        serve("t1_m2", 32'h5, 32'h2, 4'h3, 1'b0, 32'h3333_0000, 1'b1, 0);
        serve("t1_m3", 32'h1, 32'h2, 4'hC, 1'b0, 32'h4444_0000, 1'b0, 0);
        finish_campaign("t1");
        chk("t1_no_crash", {crash_detected, hang_detected}, 2'b00);

        // Hang: no response ever arrives
        start(32'h1, 32'h2, 4'h3);
        wait_req(n);
        n = 0;
        while (!hang_detected && n < 300) begin
            tick();
            n++;
        end
        chk("hang_latency", n, 100);
        chk("hang_req_dropped", dut_req_valid, 1'b0);
        finish_campaign("t2");
        chk("hang_sticky", hang_detected, 1'b1);

        // Crash on second mutant, report stalled 20 cycles on the third
        start(32'h8000_0001, 32'h3, 4'h6);
        serve("t3_m0", 32'h25A5_A5A4, 32'hFFFF_FFFC, 4'h6, 1'b0, 32'hAAAA_0001, 1'b0, 0);
        serve("t3_m1", 32'h3, 32'h8000_0001, 4'h6, 1'b1, 32'hAAAA_0002, 1'b1, 0);
        chk("t3_crash_set", crash_detected, 1'b1);
        serve("t3_m2", 32'h8000_0005, 32'h3, 4'h6, 1'b0, 32'hAAAA_0003, 1'b0, 20);
        serve("t3_m3", 32'h8000_0001, 32'h3, 4'h9, 1'b0, 32'hAAAA_0004, 1'b1, 0);
        chk("t3_crash_held", {crash_detected, hang_detected}, 2'b10);
        finish_campaign("t3");

        // Reset in the middle of APPLY, then a clean campaign
        start(32'h1, 32'h2, 4'h3);
        wait_req(n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ctrl", {isolate, dut_req_valid, rpt_valid, crash_detected, hang_detected, ack}, 6'b0);
        chk("rst_mid_data", {dut_a, dut_b, dut_op}, 68'b0);
        tick();
        chk("rst_no_ack", {ack, isolate, dut_req_valid}, 3'b000);
        start(32'h10, 32'h20, 4'h5);
        serve("t6_m0", 32'hA5A5_A5B5, 32'hFFFF_FFDF, 4'h5, 1'b0, 32'h5, 1'b0, 0);
        serve("t6_m1", 32'h20, 32'h10, 4'h5, 1'b0, 32'h6, 1'b0, 0);
        serve("t6_m2", 32'h14, 32'h20, 4'h5, 1'b0, 32'h7, 1'b0, 0);
        serve("t6_m3", 32'h10, 32'h20, 4'hA, 1'b0, 32'h8, 1'b0, 0);
        finish_campaign("t6");

        // DEPTH=4 instance with NUM_MUT=6: surplus mutants dropped
        enable_s = 1'b1;
        tick();
        enable_s = 1'b0;
        mon_valid = 1'b1;
        mon_a = 32'h1;
        mon_b = 32'h2;
        mon_op = 4'h3;
        tick();
        mon_valid = 1'b0;
        n = 0;
        applied = 0;
        first_lat = -1;
        last_op = 4'h0;
        while (!ack_s && n < 300) begin
            tick();
            n++;
            if (req_valid_s) begin
                applied++;
                if (first_lat < 0) first_lat = n;
                last_op = dut_op_s;
            end
        end
        chk("small_ack", ack_s, 1'b1);
        chk("small_first_latency", first_lat, 7);
        chk("small_applied", applied, 4);
        chk("small_last_op", last_op, 4'hC);
        chk("small_flags", {isolate_s, crash_s, hang_s}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
